// File: rtl/flopr_bist_pkg.sv
// Shared definitions for the flopr_bist self-test controller: FSM states,
// vector-table depth and counter widths.
package flopr_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_CHKRST,
        S_DRV,
        S_CMP,
        S_DONE
    } state_t;

    localparam int DEPTH  = 10;
    localparam int ERR_W  = 8;
    localparam int VNUM_W = 4;

endpackage

// File: rtl/bist_vec_rom.sv
// Combinational test-vector table: entry i holds i+1 zero-extended to N bits;
// indices past the table read as zero.
module bist_vec_rom
    import flopr_bist_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [VNUM_W-1:0] idx,
    output logic [N-1:0]      vec
);

    always_comb begin
        vec = '0;
        if (int'(idx) < DEPTH) begin
            vec = N'(idx) + N'(1);
        end
    end

endmodule

// File: rtl/flopr_bist.sv
// Built-in self-test controller for a resettable register: checks that reset
// clears it, then walks the vector table through it, counting mismatches.
module flopr_bist
    import flopr_bist_pkg::*;
#(
    parameter int N = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [N-1:0]      dut_d,
    output logic              dut_reset,
    input  logic [N-1:0]      dut_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  errors,
    output logic [VNUM_W-1:0] vectornum
);

    localparam logic [VNUM_W-1:0] LAST_VEC = VNUM_W'(DEPTH - 1);

    state_t             state_q;
    logic [ERR_W-1:0]   errors_q;
    logic [ERR_W-1:0]   errors_d;
    logic [VNUM_W-1:0]  vnum_q;
    logic [N-1:0]       vec;
    logic               mismatch_d;
    logic               drive_en;

    // The counter sticks at all-ones so a long failing run never reads as clean.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    bist_vec_rom #(
        .N (N)
    ) u_rom (
        .idx (vnum_q),
        .vec (vec)
    );

    always_comb begin
        mismatch_d = 1'b0;
        case (state_q)
            S_CHKRST: mismatch_d = (dut_q != '0);
            S_CMP:    mismatch_d = (dut_q != vec);
            default:  mismatch_d = 1'b0;
        endcase
    end

    assign errors_d = mismatch_d ? sat_inc(errors_q) : errors_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            errors_q <= '0;
            vnum_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_RST;
                        errors_q <= '0;
                        vnum_q   <= '0;
                    end
                end
                S_RST: begin
                    state_q <= S_CHKRST;
                end
                S_CHKRST: begin
                    errors_q <= errors_d;
                    vnum_q   <= '0;
                    state_q  <= S_DRV;
                end
                S_DRV: begin
                    state_q <= S_CMP;
                end
                S_CMP: begin
                    errors_q <= errors_d;
                    if (vnum_q == LAST_VEC) begin
                        state_q <= S_DONE;
                    end else begin
                        vnum_q  <= vnum_q + VNUM_W'(1);
                        state_q <= S_DRV;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Data is presented in DRV and held through CMP so the register under
    // test has captured it by the time the comparison happens.
    assign drive_en  = (state_q == S_DRV) || (state_q == S_CMP);
    assign dut_d     = drive_en ? vec : '0;
    assign dut_reset = reset || (state_q == S_RST);

    assign busy      = (state_q == S_RST) || (state_q == S_CHKRST) || drive_en;
    assign done      = (state_q == S_DONE);
    assign pass      = done && (errors_q == '0);
    assign errors    = errors_q;
    assign vectornum = vnum_q;

endmodule

// File: tb/tb_flopr_bist.sv
// Directed bench for flopr_bist driving a behavioural register under test
// that can be made healthy, stuck-at-0 on bit 0, or deaf to reset.
module tb_flopr_bist;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] dut_d;
    logic        dut_reset;
    logic [63:0] dut_q;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  errors;
    logic [3:0]  vectornum;

    logic [63:0] rut_q;
    logic        preload;
    int          fault;
    int          cyc;
    int          checks;
    int          fails;

    flopr_bist #(
        .N (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dut_d     (dut_d),
        .dut_reset (dut_reset),
        .dut_q     (dut_q),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .errors    (errors),
        .vectornum (vectornum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register under test; fault 2 means the reset path does nothing.
    always_ff @(posedge clk) begin
        if (preload) begin
            rut_q <= '1;
        end else if (dut_reset) begin
            if (fault != 2) rut_q <= '0;
        end else begin
            rut_q <= dut_d;
        end
    end
    assign dut_q = (fault == 1) ? {rut_q[63:1], 1'b0} : rut_q;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick();
        cyc   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        cyc     = 0;
        fault   = 0;
        preload = 1'b0;
        start   = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_pass",      64'(pass),      64'd0);
        chk("rst_errors",    64'(errors),    64'd0);
        chk("rst_vectornum", 64'(vectornum), 64'd0);
        chk("rst_dut_d",     dut_d,          64'd0);
        chk("rst_dut_reset", 64'(dut_reset), 64'd1);
        reset = 1'b0;
        tick();
        chk("idle_dut_reset", 64'(dut_reset), 64'd0);

        // Healthy register, with a stray start in the middle of the run.
        kick();
        chk("r1_c1_busy",      64'(busy),      64'd1);
        chk("r1_c1_dut_reset", 64'(dut_reset), 64'd1);
        tick();
        chk("r1_c2_dut_reset", 64'(dut_reset), 64'd0);
        chk("r1_c2_dut_d",     dut_d,          64'd0);
        tick();
        chk("r1_c3_dut_d",     dut_d,          64'd1);
        tick();
        chk("r1_c4_dut_d",     dut_d,          64'd1);
        chk("r1_c4_vnum",      64'(vectornum), 64'd0);
        tick();
        chk("r1_c5_dut_d",     dut_d,          64'd2);
        chk("r1_c5_vnum",      64'(vectornum), 64'd1);
        run_to(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_c9_busy",      64'(busy),      64'd1);
        chk("r1_c9_vnum",      64'(vectornum), 64'd3);
        chk("r1_c9_dut_d",     dut_d,          64'd4);
        run_to(21);
        chk("r1_c21_dut_d",    dut_d,          64'd10);
        tick();
        chk("r1_c22_done",     64'(done),      64'd0);
        chk("r1_c22_busy",     64'(busy),      64'd1);
        tick();
        chk("r1_c23_done",     64'(done),      64'd1);
        chk("r1_c23_busy",     64'(busy),      64'd0);
        chk("r1_c23_pass",     64'(pass),      64'd1);
        chk("r1_c23_errors",   64'(errors),    64'd0);
        chk("r1_c23_vnum",     64'(vectornum), 64'd9);
        chk("r1_c23_dut_d",    dut_d,          64'd0);
        run_to(26);
        chk("r1_hold_done",    64'(done),      64'd1);
        chk("r1_hold_vnum",    64'(vectornum), 64'd9);

        // Bit 0 stuck at zero: vectors 1,3,5,7,9 miscompare.
        fault = 1;
        kick();
        run_to(23);
        chk("r2_done",   64'(done),   64'd1);
        chk("r2_errors", 64'(errors), 64'd5);
        chk("r2_pass",   64'(pass),   64'd0);

        // Fixed register, restarted from DONE.
        fault = 0;
        kick();
        chk("r3_c1_errors", 64'(errors),    64'd0);
        chk("r3_c1_vnum",   64'(vectornum), 64'd0);
        run_to(22);
        chk("r3_c22_done",  64'(done),      64'd0);
        tick();
        chk("r3_done",      64'(done),      64'd1);
        chk("r3_pass",      64'(pass),      64'd1);

        // Reset ignored, register holding all-ones before the run.
        fault   = 2;
        preload = 1'b1;
        kick();
        preload = 1'b0;
        run_to(3);
        chk("r4_c3_errors", 64'(errors), 64'd1);
        run_to(23);
        chk("r4_done",   64'(done),   64'd1);
        chk("r4_errors", 64'(errors), 64'd1);
        chk("r4_pass",   64'(pass),   64'd0);

        // Abort with reset at cycle 10 while start is also held.
        fault = 1;
        kick();
        run_to(10);
        chk("r5_c10_errors", 64'(errors), 64'd2);
        reset = 1'b1;
        start = 1'b1;
        #1;
        chk("r5_c10_dut_reset", 64'(dut_reset), 64'd1);
        tick();
        chk("r5_c11_busy",      64'(busy),      64'd0);
        chk("r5_c11_errors",    64'(errors),    64'd0);
        chk("r5_c11_vnum",      64'(vectornum), 64'd0);
        chk("r5_c11_done",      64'(done),      64'd0);
        chk("r5_c11_dut_d",     dut_d,          64'd0);
        tick();
        chk("r5_c12_busy",      64'(busy),      64'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("r5_idle_busy",     64'(busy),      64'd0);
        chk("r5_idle_done",     64'(done),      64'd0);
        fault = 0;
        kick();
        run_to(23);
        chk("r6_done",   64'(done),   64'd1);
        chk("r6_pass",   64'(pass),   64'd1);
        chk("r6_errors", 64'(errors), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, fails);
        $finish;
    end

endmodule
